// File: rtl/ddr3_burst_arbiter_if.sv
// Handshake bundle between the burst arbiter, its FIFOs and the MIG UI.
// The arbiter takes the master side; FIFOs and the memory controller take the slave side.
interface ddr3_burst_arbiter_if #(
  parameter int UI_WIDTH   = 128,
  parameter int ADDR_WIDTH = 29,
  parameter int CNT_WIDTH  = 8
);
  logic                    ib_re;
  logic [UI_WIDTH-1:0]     ib_data;
  logic [CNT_WIDTH-1:0]    ib_count;
  logic                    ib_valid;
  logic                    ob_we;
  logic [UI_WIDTH-1:0]     ob_data;
  logic [CNT_WIDTH-1:0]    ob_count;
  logic                    app_rdy;
  logic                    app_en;
  logic [2:0]              app_cmd;
  logic [ADDR_WIDTH-1:0]   app_addr;
  logic                    app_wdf_rdy;
  logic                    app_wdf_wren;
  logic                    app_wdf_end;
  logic [UI_WIDTH-1:0]     app_wdf_data;
  logic [UI_WIDTH/8-1:0]   app_wdf_mask;
  logic [UI_WIDTH-1:0]     app_rd_data;
  logic                    app_rd_data_valid;

  modport master (
    output ib_re,
    input  ib_data, ib_count, ib_valid,
    output ob_we, ob_data,
    input  ob_count,
    input  app_rdy,
    output app_en, app_cmd, app_addr,
    input  app_wdf_rdy,
    output app_wdf_wren, app_wdf_end,
    output app_wdf_data, app_wdf_mask,
    input  app_rd_data, app_rd_data_valid
  );

  modport slave (
    input  ib_re,
    output ib_data, ib_count, ib_valid,
    input  ob_we, ob_data,
    output ob_count,
    output app_rdy,
    input  app_en, app_cmd, app_addr,
    output app_wdf_rdy,
    input  app_wdf_wren, app_wdf_end,
    input  app_wdf_data, app_wdf_mask,
    output app_rd_data, app_rd_data_valid
  );
endinterface

// File: rtl/ddr3_burst_arbiter.sv
// Moves bursts from an input FIFO to DDR3 and from DDR3 to an output FIFO,
// alternating write and read grants when both sides have work ready.
module ddr3_burst_arbiter #(
  parameter int              UI_WIDTH    = 128,
  parameter int              ADDR_WIDTH  = 29,
  parameter int              BURST_WORDS = 1,
  parameter int              ADDR_INCR   = 8,
  parameter longint unsigned ADDR_LIMIT  = 64'd1 << ADDR_WIDTH,
  parameter int              FIFO_DEPTH  = 256,
  parameter int              CNT_WIDTH   = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                writes_en,
  input  logic                reads_en,
  input  logic                calib_done,
  ddr3_burst_arbiter_if.master bus,
  output logic [31:0]         wr_bursts,
  output logic [31:0]         rd_bursts,
  output logic                busy
);

  typedef enum logic [2:0] {
    IDLE, WR_FETCH, WR_LATCH, WR_DATA,
    WR_CMD, RD_CMD, RD_DATA
  } state_e;

  localparam logic [31:0] WR_MIN =
    32'(BURST_WORDS);
  localparam logic [31:0] RD_LIM =
    32'(FIFO_DEPTH - 2 - BURST_WORDS);
  localparam logic [1:0] CNT_LOAD =
    2'(BURST_WORDS - 1);

  state_e                state_q, state_d;
  logic                  write_mode_q, write_mode_d;
  logic                  read_mode_q, read_mode_d;
  logic                  last_wr_q, last_wr_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_WIDTH-1:0] app_addr_q, app_addr_d;
  logic [UI_WIDTH-1:0]   wdf_data_q, wdf_data_d;
  logic                  ob_we_q, ob_we_d;
  logic [UI_WIDTH-1:0]   ob_data_q, ob_data_d;
  logic [31:0]           wr_bursts_q, wr_bursts_d;
  logic [31:0]           rd_bursts_q, rd_bursts_d;
  logic                  wr_ok, rd_ok, grant_wr;

  function automatic logic [ADDR_WIDTH-1:0] adv(
    input logic [ADDR_WIDTH-1:0] a
  );
    logic [63:0] s;
    s = 64'(a) + 64'(ADDR_INCR);
    return (s >= ADDR_LIMIT) ? '0 : s[ADDR_WIDTH-1:0];
  endfunction

  // Next-state, datapath and counter updates for the burst sequencer.
  always_comb begin
    state_d      = state_q;
    write_mode_d = writes_en;
    read_mode_d  = reads_en;
    last_wr_d    = last_wr_q;
    cnt_d        = cnt_q;
    wr_addr_d    = wr_addr_q;
    rd_addr_d    = rd_addr_q;
    app_addr_d   = app_addr_q;
    wdf_data_d   = wdf_data_q;
    ob_we_d      = 1'b0;
    ob_data_d    = ob_data_q;
    wr_bursts_d  = wr_bursts_q;
    rd_bursts_d  = rd_bursts_q;
    wr_ok = calib_done & write_mode_q &
            (32'(bus.ib_count) >= WR_MIN);
    rd_ok = calib_done & read_mode_q &
            (32'(bus.ob_count) < RD_LIM);
    grant_wr = wr_ok & (~rd_ok | ~last_wr_q);
    unique case (state_q)
      IDLE: begin
        if (wr_ok | rd_ok) begin
          cnt_d     = CNT_LOAD;
          last_wr_d = grant_wr;
          if (grant_wr) begin
            state_d    = WR_FETCH;
            app_addr_d = wr_addr_q;
          end else begin
            state_d    = RD_CMD;
            app_addr_d = rd_addr_q;
          end
        end
      end
      WR_FETCH: state_d = WR_LATCH;
      WR_LATCH: begin
        if (bus.ib_valid) begin
          wdf_data_d = bus.ib_data;
          state_d    = WR_DATA;
        end
      end
      WR_DATA: begin
        if (bus.app_wdf_rdy) begin
          if (cnt_q == 2'd0) begin
            state_d = WR_CMD;
          end else begin
            cnt_d   = cnt_q - 2'd1;
            state_d = WR_FETCH;
          end
        end
      end
      WR_CMD: begin
        if (bus.app_rdy) begin
          wr_addr_d   = adv(wr_addr_q);
          wr_bursts_d = wr_bursts_q + 32'd1;
          state_d     = IDLE;
        end
      end
      RD_CMD: begin
        if (bus.app_rdy) begin
          rd_addr_d = adv(rd_addr_q);
          state_d   = RD_DATA;
        end
      end
      RD_DATA: begin
        if (bus.app_rd_data_valid) begin
          ob_we_d   = 1'b1;
          ob_data_d = bus.app_rd_data;
          if (cnt_q == 2'd0) begin
            rd_bursts_d = rd_bursts_q + 32'd1;
            state_d     = IDLE;
          end else begin
            cnt_d = cnt_q - 2'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset drops any transaction in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      write_mode_q <= 1'b0;
      read_mode_q  <= 1'b0;
      last_wr_q    <= 1'b0;
      cnt_q        <= '0;
      wr_addr_q    <= '0;
      rd_addr_q    <= '0;
      app_addr_q   <= '0;
      wdf_data_q   <= '0;
      ob_we_q      <= 1'b0;
      ob_data_q    <= '0;
      wr_bursts_q  <= '0;
      rd_bursts_q  <= '0;
    end else begin
      state_q      <= state_d;
      write_mode_q <= write_mode_d;
      read_mode_q  <= read_mode_d;
      last_wr_q    <= last_wr_d;
      cnt_q        <= cnt_d;
      wr_addr_q    <= wr_addr_d;
      rd_addr_q    <= rd_addr_d;
      app_addr_q   <= app_addr_d;
      wdf_data_q   <= wdf_data_d;
      ob_we_q      <= ob_we_d;
      ob_data_q    <= ob_data_d;
      wr_bursts_q  <= wr_bursts_d;
      rd_bursts_q  <= rd_bursts_d;
    end
  end

  assign bus.ib_re        = (state_q == WR_FETCH);
  assign bus.app_en       = (state_q == WR_CMD) |
                            (state_q == RD_CMD);
  assign bus.app_cmd      = (state_q == RD_CMD) ?
                            3'b001 : 3'b000;
  assign bus.app_addr     = app_addr_q;
  assign bus.app_wdf_wren = (state_q == WR_DATA);
  assign bus.app_wdf_end  = (state_q == WR_DATA) &
                            (cnt_q == 2'd0);
  assign bus.app_wdf_data = wdf_data_q;
  assign bus.app_wdf_mask = '0;
  assign bus.ob_we        = ob_we_q;
  assign bus.ob_data      = ob_data_q;
  assign wr_bursts        = wr_bursts_q;
  assign rd_bursts        = rd_bursts_q;
  assign busy             = (state_q != IDLE);

endmodule

// File: tb/tb_ddr3_burst_arbiter.sv
// Bench for the DDR3 burst arbiter: FIFO/MIG responders with a
// transaction-level model, grant vectors, and directed corner cases.
module tb_ddr3_burst_arbiter;
  localparam int UIW = 32;
  localparam int AW  = 8;
  localparam int CW  = 8;
  localparam int BW  = 2;
  localparam int LIM = 32;
  localparam int FD  = 256;
  localparam int RD_LIM = FD - 2 - BW;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic wen = 0, ren = 0, calib = 0;
  logic b_wen = 0, b_ren = 0, b_calib = 0;
  logic [31:0] wr_bursts, rd_bursts;
  logic [31:0] b_wr_bursts, b_rd_bursts;
  logic busy, b_busy;

  always #5 clk = ~clk;

  ddr3_burst_arbiter_if #(
    .UI_WIDTH(UIW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)
  ) ifa ();
  ddr3_burst_arbiter_if #(
    .UI_WIDTH(UIW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)
  ) ifb ();

  ddr3_burst_arbiter #(
    .UI_WIDTH(UIW), .ADDR_WIDTH(AW),
    .BURST_WORDS(BW), .ADDR_INCR(8),
    .ADDR_LIMIT(LIM), .FIFO_DEPTH(FD),
    .CNT_WIDTH(CW)
  ) dut_a (
    .clk(clk), .reset_n(rst_n),
    .writes_en(wen), .reads_en(ren),
    .calib_done(calib), .bus(ifa),
    .wr_bursts(wr_bursts), .rd_bursts(rd_bursts),
    .busy(busy)
  );

  ddr3_burst_arbiter #(
    .UI_WIDTH(UIW), .ADDR_WIDTH(AW),
    .BURST_WORDS(1), .ADDR_INCR(8),
    .FIFO_DEPTH(FD), .CNT_WIDTH(CW)
  ) dut_b (
    .clk(clk), .reset_n(rst_n),
    .writes_en(b_wen), .reads_en(b_ren),
    .calib_done(b_calib), .bus(ifb),
    .wr_bursts(b_wr_bursts),
    .rd_bursts(b_rd_bursts),
    .busy(b_busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(input string nm,
      input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endfunction

  function automatic bit pct(input int p);
    return int'($urandom_range(1, 100)) <= p;
  endfunction

  // environment state (input FIFO, MIG, output FIFO, model)
  logic [31:0] ib_q[$];
  logic [31:0] exp_wd[$];
  logic [31:0] exp_rd[$];
  logic [32:0] wbeats[$];
  int cmd_log[$];
  int waddr_log[$];
  logic [31:0] hold;
  int pend = 0, rd_left = 0, rd_gap = 0;
  int m_wr_addr = 0, m_rd_addr = 0;
  int m_wr_n = 0, m_rd_n = 0;
  int rdy_pct = 100, wdf_pct = 100;
  int lat_max = 0, gap_max = 0;
  int stall_left = 0, stall_seen = 0;
  int en_rises = 0, cmd_acc = 0;
  bit prev_en = 0;

  function automatic int nxt(input int a);
    return (a + 8 >= LIM) ? 0 : a + 8;
  endfunction

  task automatic env_cmd();
    cmd_acc++;
    if (ifa.app_cmd == 3'b000) begin
      chk("wr_beats", wbeats.size(), BW);
      foreach (wbeats[i]) begin
        chk("wr_end", wbeats[i][32], i == BW - 1);
        if (exp_wd.size() > 0)
          chk("wr_data", wbeats[i][31:0],
              exp_wd.pop_front());
      end
      wbeats.delete();
      chk("wr_addr", ifa.app_addr, m_wr_addr);
      waddr_log.push_back(int'(ifa.app_addr));
      m_wr_addr = nxt(m_wr_addr);
      m_wr_n++;
      cmd_log.push_back(0);
    end else if (ifa.app_cmd == 3'b001) begin
      chk("rd_addr", ifa.app_addr, m_rd_addr);
      m_rd_addr = nxt(m_rd_addr);
      m_rd_n++;
      rd_left = BW;
      rd_gap = $urandom_range(0, gap_max);
      cmd_log.push_back(1);
    end else begin
      chk("app_cmd", ifa.app_cmd, 3'b001);
    end
  endtask

  task automatic env_step();
    if (!rst_n) begin
      ifa.ib_valid = 0;
      ifa.app_rd_data_valid = 0;
      pend = 0; rd_left = 0; rd_gap = 0;
      exp_wd.delete(); exp_rd.delete();
      wbeats.delete(); cmd_log.delete();
      waddr_log.delete();
      m_wr_addr = 0; m_rd_addr = 0;
      m_wr_n = 0; m_rd_n = 0;
      stall_seen = 0; en_rises = 0;
      cmd_acc = 0; prev_en = 0;
      ifa.ib_count = CW'(ib_q.size());
      return;
    end
    if (ifa.ob_we) begin
      if (exp_rd.size() == 0)
        chk("ob_we_unexpected", ifa.ob_we, 0);
      else
        chk("ob_data", ifa.ob_data, exp_rd.pop_front());
    end
    ifa.ib_valid = 0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        ifa.ib_valid = 1;
        ifa.ib_data = hold;
      end
    end
    if (ifa.ib_re) begin
      if (ib_q.size() == 0) begin
        chk("ib_underrun", ifa.ib_re, 0);
      end else begin
        hold = ib_q.pop_front();
        exp_wd.push_back(hold);
        pend = 1 + $urandom_range(0, lat_max);
      end
    end
    ifa.ib_count = CW'(ib_q.size());
    ifa.app_rd_data_valid = 0;
    if (rd_left > 0) begin
      if (rd_gap > 0) begin
        rd_gap--;
      end else begin
        ifa.app_rd_data_valid = 1;
        ifa.app_rd_data = $urandom;
        exp_rd.push_back(ifa.app_rd_data);
        rd_left--;
        rd_gap = $urandom_range(0, gap_max);
      end
    end
    ifa.app_wdf_rdy = pct(wdf_pct);
    if (ifa.app_wdf_wren && ifa.app_wdf_rdy) begin
      chk("wdf_mask", ifa.app_wdf_mask, 0);
      wbeats.push_back({ifa.app_wdf_end,
                        ifa.app_wdf_data});
    end
    if (ifa.app_en && !prev_en) en_rises++;
    prev_en = ifa.app_en;
    if (ifa.app_en && stall_left > 0) begin
      ifa.app_rdy = 0;
      stall_left--;
      stall_seen++;
    end else begin
      ifa.app_rdy = pct(rdy_pct);
    end
    if (ifa.app_en && ifa.app_rdy) env_cmd();
  endtask

  initial begin
    ifa.ib_valid = 0; ifa.ib_data = '0;
    ifa.ib_count = '0; ifa.app_rdy = 1;
    ifa.app_wdf_rdy = 1; ifa.app_rd_data = '0;
    ifa.app_rd_data_valid = 0;
    forever begin
      @(negedge clk);
      env_step();
    end
  end

  task automatic do_reset();
    rst_n = 0; wen = 0; ren = 0;
    ib_q.delete();
    rdy_pct = 100; wdf_pct = 100;
    lat_max = 0; gap_max = 0; stall_left = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic fill(input int n);
    for (int i = 0; i < n; i++)
      ib_q.push_back($urandom);
  endtask

  task automatic wait_idle();
    int quiet;
    bit done;
    wen = 0; ren = 0; quiet = 0; done = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (!busy && rd_left == 0 && !ifa.ob_we)
        quiet++;
      else
        quiet = 0;
      if (quiet >= 3) done = 1;
    end
    chk("idle_timeout", done, 1);
  endtask

  function automatic logic [63:0] a_outs();
    return {ifa.ib_re, ifa.ob_we, ifa.app_en,
            ifa.app_wdf_wren, ifa.app_wdf_end,
            ifa.app_cmd, ifa.app_wdf_mask, busy};
  endfunction

  task automatic b_write(input int ea,
                         input logic [31:0] d,
                         input int nb);
    bit seen;
    seen = 0;
    ifb.ib_count = 1;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (ifb.ib_re) seen = 1;
    end
    chk("b_ib_re", seen, 1);
    ifb.ib_count = 0;
    @(negedge clk);
    chk("b_ib_re_once", ifb.ib_re, 0);
    ifb.ib_valid = 1;
    ifb.ib_data = d;
    @(negedge clk);
    ifb.ib_valid = 0;
    chk("b_wren_end", {ifb.app_wdf_wren,
        ifb.app_wdf_end, ifb.app_en}, 3'b110);
    chk("b_wdf_data", ifb.app_wdf_data, d);
    @(negedge clk);
    chk("b_cmd", {ifb.app_en, ifb.app_cmd,
        ifb.app_wdf_wren}, 5'b1_000_0);
    chk("b_addr", ifb.app_addr, ea);
    @(negedge clk);
    chk("b_wr_bursts", b_wr_bursts, nb);
    chk("b_idle", {b_busy, ifb.app_en}, 0);
  endtask

  typedef struct {
    bit w; bit r; bit c;
    int ibn; int obn; int eg;
  } vec_t;

  vec_t vt[9];
  int exp_wa[5] = '{0, 8, 16, 24, 0};
  int exp_gr[4] = '{0, 1, 0, 1};

  initial begin
    int g;
    bit anyb, ok, flag;
    vt[0] = '{1, 0, 1, 2, 0, 1};
    vt[1] = '{1, 0, 1, 1, 0, 0};
    vt[2] = '{0, 1, 1, 0, RD_LIM - 1, 2};
    vt[3] = '{0, 1, 1, 0, RD_LIM, 0};
    vt[4] = '{1, 1, 0, 4, 0, 0};
    vt[5] = '{1, 1, 1, 4, 0, 1};
    vt[6] = '{0, 0, 1, 4, 0, 0};
    vt[7] = '{1, 1, 1, 0, 0, 2};
    vt[8] = '{1, 1, 1, 4, RD_LIM, 1};

    ifa.ob_count = '0;
    ifb.ib_data = '0; ifb.ib_count = '0;
    ifb.ib_valid = 0; ifb.ob_count = '0;
    ifb.app_rdy = 1; ifb.app_wdf_rdy = 1;
    ifb.app_rd_data = '0;
    ifb.app_rd_data_valid = 0;

    // asynchronous reset state, before any clock edge
    #2 rst_n = 0;
    #1;
    chk("rst_outs", a_outs(), 0);
    chk("rst_cnt", {wr_bursts, rd_bursts}, 0);
    chk("rst_addr", ifa.app_addr, 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);

    // single-word write burst on the second instance
    b_calib = 1; b_wen = 1;
    b_write(0, 32'hA5A5_1234, 1);
    b_write(8, 32'h0BAD_F00D, 2);
    b_wen = 0;

    // grant table: gating boundaries and first contention
    foreach (vt[k]) begin
      do_reset();
      fill(vt[k].ibn);
      ifa.ob_count = CW'(vt[k].obn);
      calib = vt[k].c;
      wen = vt[k].w;
      ren = vt[k].r;
      g = 0; anyb = 0;
      for (int i = 0; i < 12 && g == 0; i++) begin
        @(negedge clk);
        if (busy) anyb = 1;
        if (ifa.ib_re) g = 1;
        else if (ifa.app_en && ifa.app_cmd == 3'b001)
          g = 2;
      end
      chk($sformatf("vec%0d_grant", k), g, vt[k].eg);
      if (vt[k].eg == 0)
        chk($sformatf("vec%0d_busy", k), anyb, 0);
      wait_idle();
      chk($sformatf("vec%0d_wrb", k), wr_bursts, m_wr_n);
      chk($sformatf("vec%0d_rdb", k), rd_bursts, m_rd_n);
      chk($sformatf("vec%0d_drain", k),
          exp_rd.size() + wbeats.size(), 0);
    end

    // contention alternates write/read
    do_reset();
    fill(8);
    ifa.ob_count = '0;
    calib = 1; wen = 1; ren = 1;
    ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (cmd_log.size() >= 4) ok = 1;
    end
    chk("contend_timeout", ok, 1);
    wait_idle();
    for (int i = 0; i < 4; i++)
      chk($sformatf("contend_%0d", i),
          (i < cmd_log.size()) ? cmd_log[i] : 9,
          exp_gr[i]);

    // write address wraps at the limit
    do_reset();
    fill(10);
    calib = 1; wen = 1;
    ok = 0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      if (waddr_log.size() >= 5) ok = 1;
    end
    chk("wrap_timeout", ok, 1);
    wait_idle();
    for (int i = 0; i < 5; i++)
      chk($sformatf("wrap_%0d", i),
          (i < waddr_log.size()) ? waddr_log[i] : 99,
          exp_wa[i]);

    // command held through five stalled cycles
    do_reset();
    stall_left = 5;
    fill(2);
    calib = 1; wen = 1;
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (cmd_acc >= 1) ok = 1;
    end
    chk("stall_timeout", ok, 1);
    wait_idle();
    chk("stall_cycles", stall_seen, 5);
    chk("stall_cmds", cmd_acc, 1);
    chk("stall_en_rises", en_rises, 1);
    chk("stall_wrb", wr_bursts, 1);

    // reset mid WR_DATA clears everything at once
    do_reset();
    fill(4);
    calib = 1; wen = 1;
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (m_wr_n >= 1) begin
        wdf_pct = 0;
        ok = 1;
      end
    end
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (ifa.app_wdf_wren) ok = 1;
    end
    chk("rst_wrdata_reach", ok, 1);
    chk("rst_pre_addr", ifa.app_addr, 8);
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("rst_mid_outs", a_outs(), 0);
    chk("rst_mid_addr", ifa.app_addr, 0);
    chk("rst_mid_data",
        {ifa.app_wdf_data, ifa.ob_data}, 0);
    chk("rst_mid_cnt", {wr_bursts, rd_bursts}, 0);
    wen = 0; wdf_pct = 100;
    repeat (2) @(negedge clk);
    rst_n = 1;
    flag = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ifa.ib_re || ifa.app_en || ifa.ob_we || busy)
        flag = 1;
    end
    chk("rst_quiet", flag, 0);

    // randomized traffic against the transaction model
    do_reset();
    rdy_pct = $urandom_range(40, 100);
    wdf_pct = $urandom_range(40, 100);
    lat_max = 2; gap_max = 3;
    fill(40);
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (c % 16 == 0) begin
        wen = pct(70); ren = pct(70);
        calib = pct(85);
        ifa.ob_count = pct(80) ?
          CW'($urandom_range(0, RD_LIM - 1)) :
          CW'($urandom_range(RD_LIM, 255));
        if (ib_q.size() < 6) fill(8);
      end
    end
    wait_idle();
    chk("rand_wrb", wr_bursts, m_wr_n);
    chk("rand_rdb", rd_bursts, m_rd_n);
    chk("rand_drain", exp_rd.size() +
        exp_wd.size() + wbeats.size(), 0);
    chk("rand_activity", (m_wr_n > 2) && (m_rd_n > 2), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ddr3_burst_arbiter.md
DDR3_BURST_ARBITER -- requirements
Module: ddr3_burst_arbiter

Parameters
REQ-001 SHALL have parameter UI_WIDTH, default 128: MIG UI data width in bits; mask width is UI_WIDTH/8.
REQ-002 SHALL have parameter ADDR_WIDTH, default 29: UI address width.
REQ-003 SHALL have parameter BURST_WORDS, default 1, legal 1..4: UI words per command.
REQ-004 SHALL have parameter ADDR_INCR, default 8: address step per command (BL8).
REQ-005 SHALL have parameter ADDR_LIMIT, default 2**ADDR_WIDTH: wrap point, a multiple of ADDR_INCR.
REQ-006 SHALL have parameter FIFO_DEPTH, default 256, and parameter CNT_WIDTH, default 8: output-FIFO depth and FIFO count width.

Interface
REQ-007 SHALL have ports (name  direction  width  meaning):
clk  in  1  single clock; all logic on rising edge.
reset_n  in  1  asynchronous, active-low reset.
writes_en, reads_en, calib_done  in  1  mode enables, MIG calibration complete.
ib_re  out  1 / ib_data  in  UI_WIDTH / ib_count  in  CNT_WIDTH / ib_valid  in  1  input-FIFO read side.
ob_we  out  1 / ob_data  out  UI_WIDTH / ob_count  in  CNT_WIDTH  output-FIFO write side.
app_rdy  in  1 / app_en  out  1 / app_cmd  out  3 / app_addr  out  ADDR_WIDTH  MIG command.
app_wdf_rdy  in  1 / app_wdf_wren, app_wdf_end  out  1 / app_wdf_data  out  UI_WIDTH / app_wdf_mask  out  UI_WIDTH/8  MIG write data.
app_rd_data  in  UI_WIDTH / app_rd_data_valid  in  1  MIG read data.
wr_bursts, rd_bursts  out  32  completed-command counters.
busy  out  1  high when state != IDLE.

Function
REQ-008 SHALL register writes_en and reads_en once (write_mode, read_mode) before use.
REQ-009 SHALL drive app_wdf_mask constant all-zero.
REQ-010 SHALL implement states IDLE, WR_FETCH, WR_LATCH, WR_DATA, WR_CMD, RD_CMD, RD_DATA.
REQ-011 IDLE: wr_ok = calib_done & write_mode & (ib_count >= BURST_WORDS); rd_ok = calib_done & read_mode & (ob_count < FIFO_DEPTH-2-BURST_WORDS).
REQ-012 IDLE, only one ok: go to WR_FETCH (app_addr <= wr_addr) or RD_CMD (app_addr <= rd_addr); word counter loaded to BURST_WORDS-1.
REQ-013 IDLE, both ok: grant the opposite of last_grant; last_grant resets to read, so the first contended grant is write.
REQ-014 WR_FETCH: ib_re=1 for exactly one cycle -> WR_LATCH.
REQ-015 WR_LATCH: wait for ib_valid; then app_wdf_data <= ib_data -> WR_DATA.
REQ-016 WR_DATA: app_wdf_wren=1 and app_wdf_end=(word counter==0), held until app_wdf_rdy=1.
REQ-016a On that WR_DATA accept: non-last word -> decrement counter, WR_FETCH; last word -> WR_CMD.
REQ-017 WR_CMD: app_en=1, app_cmd=3'b000 held until app_rdy=1; on accept: wr_addr advances, wr_bursts++, -> IDLE.
REQ-018 RD_CMD: app_en=1, app_cmd=3'b001 held until app_rdy=1; on accept: rd_addr advances, -> RD_DATA.
REQ-019 RD_DATA: each app_rd_data_valid -> ob_data <= app_rd_data with ob_we=1 next cycle; after BURST_WORDS words -> rd_bursts++, IDLE.
REQ-020 Address advance: addr+ADDR_INCR >= ADDR_LIMIT -> 0, else addr+ADDR_INCR; wr_addr and rd_addr independent.
REQ-021 app_en, app_wdf_wren, app_wdf_end, ib_re, ob_we SHALL be 0 in any state/cycle not listed above.
REQ-022 Deassertion of writes_en, reads_en or calib_done mid-transaction SHALL NOT abort it; it only blocks the next grant.
REQ-023 wr_bursts and rd_bursts SHALL wrap modulo 2**32.

Reset
REQ-024 reset_n=0 SHALL immediately clear to 0 (no clock needed): state=IDLE, all outputs, wr_addr, rd_addr, counters, write_mode, read_mode; last_grant=read.
REQ-025 Reset asserted mid-transaction SHALL abandon it; no ib_re, app_en or ob_we is issued afterwards until a new grant.

Verification
REQ-026 Write, BURST_WORDS=1: calib=1, writes_en=1, ib_count=1 -> one ib_re; app_wdf_wren+end with ib_data; app_en cmd 000 addr 0; wr_bursts=1; next addr 8.
REQ-027 Read, BURST_WORDS=2: reads_en=1, ob_count=0, two valids D0,D1 -> cmd 001 addr 0; ob_we twice, data D0 then D1; rd_bursts=1.
REQ-028 Contention: both enables, both ok -> grants W,R,W,R in order.
REQ-029 Wrap: ADDR_LIMIT=32 -> write addresses 0,8,16,24,0.
REQ-030 Backpressure and reset: app_rdy=0 for 5 cycles -> app_en held 5 cycles, one command; reset_n=0 in WR_DATA -> all outputs 0 same cycle, busy=0.
REQ-031 Gating: ob_count=FIFO_DEPTH-2-BURST_WORDS or calib_done=0 -> no grant, busy stays 0.
